// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns,
// special glyph codes and the per-slot FSM state encoding.
package seg_pkg;

   // Segment order {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_UNDER = 7'h77;
   localparam logic [6:0] SEG_O     = 7'h23;

   localparam logic [4:0] CODE_BLANK = 5'h10;
   localparam logic [4:0] CODE_DASH  = 5'h11;
   localparam logic [4:0] CODE_UNDER = 5'h12;
   localparam logic [4:0] CODE_O     = 5'h13;

   typedef enum logic {
      BLANK = 1'b0,
      PWM   = 1'b1
   } state_e;

endpackage

// File: rtl/seg_code_decode.sv
// Combinational 5-bit digit code to active-low {g,f,e,d,c,b,a} segments.
// Codes 0x00-0x0F are hex digits, 0x11-0x13 are glyphs, everything else is dark.
module seg_code_decode
   import seg_pkg::*;
(
   input  logic [4:0] code_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (code_i)
         5'h00: seg_o = 7'h40;
         5'h01: seg_o = 7'h79;
         5'h02: seg_o = 7'h24;
         5'h03: seg_o = 7'h30;
         5'h04: seg_o = 7'h19;
         5'h05: seg_o = 7'h12;
         5'h06: seg_o = 7'h02;
         5'h07: seg_o = 7'h78;
         5'h08: seg_o = 7'h00;
         5'h09: seg_o = 7'h10;
         5'h0A: seg_o = 7'h08;
         5'h0B: seg_o = 7'h03;
         5'h0C: seg_o = 7'h46;
         5'h0D: seg_o = 7'h21;
         5'h0E: seg_o = 7'h06;
         5'h0F: seg_o = 7'h0E;
         CODE_BLANK: seg_o = SEG_BLANK;
         CODE_DASH:  seg_o = SEG_DASH;
         CODE_UNDER: seg_o = SEG_UNDER;
         CODE_O:     seg_o = SEG_O;
         default:    seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed N-digit common-anode driver: per-slot blanking gap, PWM brightness,
// inputs snapshotted once per frame; all pins registered (one cycle behind the FSM).
module seven_segment_scan
   import seg_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int BLANK_CYC = 64,
   parameter int DIV_STEP  = 256,
   parameter int BR_W      = 3
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5*N_DIGITS-1:0] digits_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   digit_en,
   input  logic [BR_W-1:0]       brightness,
   output logic [N_DIGITS-1:0]   AN,
   output logic [6:0]            seven_out,
   output logic                  dp_out,
   output logic                  frame_done
);

   localparam int CNT_MAX = (BLANK_CYC > DIV_STEP) ? BLANK_CYC : DIV_STEP;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int SLOT_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   state_e                state_q, state_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BR_W-1:0]       level_q, level_d;
   logic                  first_q;
   logic                  snap, frame_end;

   logic [5*N_DIGITS-1:0] dig_sh_q;
   logic [N_DIGITS-1:0]   dp_sh_q, en_sh_q;
   logic [BR_W-1:0]       br_sh_q;

   logic [N_DIGITS-1:0]   an_q, an_d;
   logic [6:0]            seg_q, seg_d, seg_dec;
   logic                  dp_q, dp_d, fd_q;
   logic [4:0]            code_mux;
   logic                  lit;

   // The first edge after reset only opens frame 0 (snapshot) without counting a blank cycle.
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      snap      = 1'b0;
      frame_end = 1'b0;
      if (first_q) begin
         snap = 1'b1;
      end else begin
         case (state_q)
            BLANK: begin
               if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
                  state_d = PWM;
                  cnt_d   = '0;
                  level_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            PWM: begin
               if (cnt_q == CNT_W'(DIV_STEP - 1)) begin
                  cnt_d = '0;
                  if (level_q == '1) begin
                     state_d = BLANK;
                     if (slot_q == SLOT_W'(N_DIGITS - 1)) begin
                        slot_d    = '0;
                        snap      = 1'b1;
                        frame_end = 1'b1;
                     end else begin
                        slot_d = slot_q + 1'b1;
                     end
                  end else begin
                     level_d = level_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = BLANK;
         endcase
      end
   end

   always_comb begin
      code_mux = dig_sh_q[5*int'(slot_q) +: 5];
      lit      = (state_q == PWM) && (level_q < br_sh_q) && en_sh_q[slot_q];
      an_d     = '1;
      seg_d    = SEG_BLANK;
      dp_d     = 1'b1;
      if (lit) begin
         an_d  = ~(N_DIGITS'(1) << slot_q);
         seg_d = seg_dec;
         dp_d  = ~dp_sh_q[slot_q];
      end
   end

   seg_code_decode u_decode (
      .code_i (code_mux),
      .seg_o  (seg_dec)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= BLANK;
         slot_q   <= '0;
         cnt_q    <= '0;
         level_q  <= '0;
         first_q  <= 1'b1;
         dig_sh_q <= '0;
         dp_sh_q  <= '0;
         en_sh_q  <= '0;
         br_sh_q  <= '0;
         an_q     <= '1;
         seg_q    <= SEG_BLANK;
         dp_q     <= 1'b1;
         fd_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         first_q <= 1'b0;
         if (snap) begin
            dig_sh_q <= digits_in;
            dp_sh_q  <= dp_in;
            en_sh_q  <= digit_en;
            br_sh_q  <= brightness;
         end
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
         fd_q  <= frame_end;
      end
   end

   assign AN         = an_q;
   assign seven_out  = seg_q;
   assign dp_out     = dp_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan with N=4, BLANK_CYC=2, DIV_STEP=1, BR_W=2 (6-cycle slots, 24-cycle frames).
// Expected pins come from frame/slot position arithmetic on a per-frame input snapshot.
module tb_seven_segment_scan;

   localparam int FRAME = 24;
   localparam int SLOT  = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [19:0] digits_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  digit_en = '0;
   logic [1:0]  brightness = '0;
   logic [3:0]  AN;
   logic [6:0]  seven_out;
   logic        dp_out;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int k = 0;

   logic [19:0] sh_dig = '0;
   logic [3:0]  sh_dp = '0;
   logic [3:0]  sh_en = '0;
   logic [1:0]  sh_br = '0;

   logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [6:0] dec_tab [32];

   seven_segment_scan #(
      .N_DIGITS  (4),
      .BLANK_CYC (2),
      .DIV_STEP  (1),
      .BR_W      (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .brightness (brightness),
      .AN         (AN),
      .seven_out  (seven_out),
      .dp_out     (dp_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, k);
      end
   endtask

   // Pins after edge k show the frame position reached at edge k-1; frames open at edges 1, 25, 49, ...
   task automatic step();
      logic [19:0] c_dig;
      logic [3:0]  c_dp, c_en, e_an;
      logic [1:0]  c_br;
      logic [6:0]  e_seg;
      logic        e_dp, e_fd;
      int          t, sl, pos;
      c_dig = digits_in;
      c_dp  = dp_in;
      c_en  = digit_en;
      c_br  = brightness;
      @(posedge clk);
      #1;
      k++;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_fd  = 1'b0;
      if (k >= 2) begin
         t   = (k - 2) % FRAME;
         sl  = t / SLOT;
         pos = t % SLOT;
         if (pos >= 2 && (pos - 2) < int'(sh_br) && sh_en[sl]) begin
            e_an  = ~(4'b0001 << sl);
            e_seg = dec_tab[sh_dig[sl*5 +: 5]];
            e_dp  = ~sh_dp[sl];
         end
         e_fd = (t == FRAME - 1);
      end
      check("AN", 32'(AN), 32'(e_an));
      check("seven_out", 32'(seven_out), 32'(e_seg));
      check("dp_out", 32'(dp_out), 32'(e_dp));
      check("frame_done", 32'(frame_done), 32'(e_fd));
      if ((k - 1) % FRAME == 0) begin
         sh_dig = c_dig;
         sh_dp  = c_dp;
         sh_en  = c_en;
         sh_br  = c_br;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic randomize_inputs();
      digits_in  = 20'($urandom);
      dp_in      = 4'($urandom);
      digit_en   = 4'($urandom);
      brightness = 2'($urandom);
   endtask

   initial begin
      logic found;
      int   r;
      for (int i = 0; i < 32; i++) dec_tab[i] = 7'h7F;
      for (int i = 0; i < 16; i++) dec_tab[i] = hex7[i];
      dec_tab[17] = 7'h3F;
      dec_tab[18] = 7'h77;
      dec_tab[19] = 7'h23;

      // Reset held with the clock running.
      repeat (3) @(posedge clk);
      #1;
      check("rst_AN", 32'(AN), 32'h0F);
      check("rst_seven_out", 32'(seven_out), 32'h7F);
      check("rst_dp_out", 32'(dp_out), 32'h1);
      check("rst_frame_done", 32'(frame_done), 32'h0);

      digits_in  = {5'h03, 5'h02, 5'h01, 5'h00};
      digit_en   = 4'hF;
      dp_in      = 4'h0;
      brightness = 2'd3;
      rst = 1'b1;
      run(2 * FRAME);

      brightness = 2'd1;
      run(FRAME);
      brightness = 2'd0;
      run(FRAME);

      brightness = 2'd3;
      digit_en   = 4'b0101;
      dp_in      = 4'b0001;
      run(FRAME);

      // Mid-frame change lands during slot 1 and must wait for the next frame.
      digit_en = 4'hF;
      run(8);
      digits_in = {5'h0D, 5'h0C, 5'h0B, 5'h0A};
      dp_in     = 4'b1010;
      run(FRAME - 8);
      run(FRAME);

      digits_in = {5'h13, 5'h12, 5'h11, 5'h10};
      run(FRAME);
      digits_in = {5'h1F, 5'h1F, 5'h1F, 5'h1F};
      run(FRAME);

      for (int f = 0; f < 20; f++) begin
         randomize_inputs();
         r = $urandom_range(1, FRAME - 1);
         run(r);
         randomize_inputs();
         run(FRAME - r);
      end

      // Reset asserted asynchronously in the middle of a lit cycle.
      digits_in  = 20'($urandom);
      digit_en   = 4'hF;
      brightness = 2'd3;
      run(FRAME);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         if (AN !== 4'hF) found = 1'b1;
      end
      check("lit_window_found", 32'(found), 32'h1);
      #3;
      rst = 1'b0;
      #1;
      check("async_rst_AN", 32'(AN), 32'h0F);
      check("async_rst_seven_out", 32'(seven_out), 32'h7F);
      check("async_rst_dp_out", 32'(dp_out), 32'h1);
      check("async_rst_frame_done", 32'(frame_done), 32'h0);
      #2;
      k = 0;
      sh_dig = '0;
      sh_dp  = '0;
      sh_en  = '0;
      sh_br  = '0;
      rst = 1'b1;
      run(FRAME);
      for (int f = 0; f < 3; f++) begin
         randomize_inputs();
         run(FRAME);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
